// File: rtl/capture_ctrl_if.sv
// Capture sequencer bus: software commands, sample strobe and trigger in;
// RAM write port and capture status out. master = driver, slave = sequencer.
interface capture_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              run;
  logic              clr_cap_done;
  logic              wrt_smpl;
  logic              triggered;
  logic [ADDR_W-1:0] trig_pos;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              armed;
  logic              set_capture_done;
  logic              capture_done;
  logic              busy;

  modport master (
    output run,
    output clr_cap_done,
    output wrt_smpl,
    output triggered,
    output trig_pos,
    input  we,
    input  waddr,
    input  armed,
    input  set_capture_done,
    input  capture_done,
    input  busy
  );

  modport slave (
    input  run,
    input  clr_cap_done,
    input  wrt_smpl,
    input  triggered,
    input  trig_pos,
    output we,
    output waddr,
    output armed,
    output set_capture_done,
    output capture_done,
    output busy
  );
endinterface

// File: rtl/capture_ctrl.sv
// Logic analyzer capture sequencer: fills a circular sample RAM, arms the
// trigger once enough history exists, collects trig_pos post-trigger samples.
// Ports: clk, rst_n (async, active-low), bus (capture_ctrl_if.slave).
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WRT  = 2'd1;
  localparam logic [1:0] POST = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // DEPTH expressed in the ADDR_W+1 bit counter domain
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   smpl_cnt_q, smpl_cnt_d;
  logic              armed_q, armed_d;
  logic              set_done_q, set_done_d;
  logic              cap_done_q, cap_done_d;

  logic              in_wrt;
  logic              in_post;
  logic              post_full;
  logic              start;
  logic              we;
  logic [ADDR_W:0]   arm_thr;

  assign in_wrt    = (state_q == WRT);
  assign in_post   = (state_q == POST);
  assign post_full = (post_cnt_q == bus.trig_pos);

  // run starts from IDLE and restarts from WRT/POST; DONE ignores it
  assign start = bus.run & (state_q != DONE);

  assign we = bus.wrt_smpl &
              (in_wrt | (in_post & ~post_full));

  // history needed before the trigger may fire
  assign arm_thr = DEPTH_C - {1'b0, bus.trig_pos};

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    post_cnt_d = post_cnt_q;
    smpl_cnt_d = smpl_cnt_q;
    armed_d    = armed_q;
    set_done_d = 1'b0;
    cap_done_d = cap_done_q;

    if (start) begin
      state_d    = WRT;
      waddr_d    = '0;
      post_cnt_d = '0;
      smpl_cnt_d = '0;
      armed_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        WRT: begin
          if (we) begin
            waddr_d = waddr_q + 1'b1;
            if (smpl_cnt_q != DEPTH_C)
              smpl_cnt_d = smpl_cnt_q + 1'b1;
          end
          // uses the updated count so armed rises
          // the cycle after the qualifying write
          armed_d = armed_q | (smpl_cnt_d >= arm_thr);
          if (bus.triggered)
            state_d = POST;
        end
        POST: begin
          if (post_full) begin
            state_d    = DONE;
            set_done_d = 1'b1;
            cap_done_d = 1'b1;
            armed_d    = 1'b0;
          end else if (we) begin
            waddr_d    = waddr_q + 1'b1;
            post_cnt_d = post_cnt_q + 1'b1;
          end
        end
        DONE: begin
          // waddr stays frozen on the oldest sample
          if (bus.clr_cap_done) begin
            state_d    = IDLE;
            cap_done_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      post_cnt_q <= '0;
      smpl_cnt_q <= '0;
      armed_q    <= 1'b0;
      set_done_q <= 1'b0;
      cap_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      post_cnt_q <= post_cnt_d;
      smpl_cnt_q <= smpl_cnt_d;
      armed_q    <= armed_d;
      set_done_q <= set_done_d;
      cap_done_q <= cap_done_d;
    end
  end

  assign bus.we               = we;
  assign bus.waddr            = waddr_q;
  assign bus.armed            = armed_q;
  assign bus.set_capture_done = set_done_q;
  assign bus.capture_done     = cap_done_q;
  assign bus.busy             = in_wrt | in_post;

endmodule

// File: tb/tb_capture_ctrl.sv
// Testbench for capture_ctrl at ADDR_W=3: vector table for the
// basic capture plus hand sequences; RAM writes go through a scoreboard.
module tb_capture_ctrl;

  localparam int AW = 3;

  logic clk;
  logic rst_n;

  capture_ctrl_if #(.ADDR_W(AW)) bus ();

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       run;
    logic       clr;
    logic       wrt;
    logic       trig;
    logic [7:0] exp;
  } vec_t;

  vec_t          tbl[$];
  logic [AW-1:0] exp_q[$];
  int            nvec;
  int            nerr;

  function automatic vec_t v(
    input logic r, input logic c,
    input logic w, input logic t,
    input logic e_we, input int e_wa,
    input logic e_arm, input logic e_sd,
    input logic e_cd, input logic e_busy
  );
    vec_t x;
    x.run  = r;
    x.clr  = c;
    x.wrt  = w;
    x.trig = t;
    x.exp  = {e_we, 3'(e_wa), e_arm,
              e_sd, e_cd, e_busy};
    return x;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push_addrs(input int first, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(AW'(first + i));
  endtask

  // every RAM write must match the next queued address
  task automatic sb_check();
    logic [AW-1:0] e;
    if (bus.we === 1'b1) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL sb_unexpected_we: waddr %0h",
                 bus.waddr);
      end else begin
        e = exp_q.pop_front();
        if (bus.waddr !== e) begin
          nerr++;
          $display("FAIL sb_waddr: got %0h expected %0h",
                   bus.waddr, e);
        end
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    sb_check();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    neg();
    pos();
  endtask

  function automatic logic [7:0] outs();
    return {bus.we, bus.waddr, bus.armed,
            bus.set_capture_done,
            bus.capture_done, bus.busy};
  endfunction

  initial begin
    int n;
    nvec = 0;
    nerr = 0;
    rst_n            = 1'b0;
    bus.run          = 1'b0;
    bus.clr_cap_done = 1'b0;
    bus.wrt_smpl     = 1'b0;
    bus.triggered    = 1'b0;
    bus.trig_pos     = 3'd3;

    #2;
    chk("reset_outs", 32'(outs()), 32'h0);
    pos();
    rst_n = 1'b1;

    // basic capture, trig_pos=3, continuous samples
    tbl.push_back(v(1,0,1,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,1,0, 1,0,0,0,0,1));
    tbl.push_back(v(0,0,1,0, 1,1,0,0,0,1));
    tbl.push_back(v(0,0,1,0, 1,2,0,0,0,1));
    tbl.push_back(v(0,0,1,0, 1,3,0,0,0,1));
    tbl.push_back(v(0,0,1,0, 1,4,0,0,0,1));
    tbl.push_back(v(0,0,1,0, 1,5,1,0,0,1));
    tbl.push_back(v(0,0,1,1, 1,6,1,0,0,1));
    tbl.push_back(v(0,0,1,1, 1,7,1,0,0,1));
    tbl.push_back(v(0,0,1,1, 1,0,1,0,0,1));
    tbl.push_back(v(0,0,1,1, 1,1,1,0,0,1));
    tbl.push_back(v(0,0,1,1, 0,2,1,0,0,1));
    tbl.push_back(v(0,0,1,0, 0,2,0,1,1,0));
    tbl.push_back(v(0,0,1,0, 0,2,0,0,1,0));
    tbl.push_back(v(1,0,1,0, 0,2,0,0,1,0));
    tbl.push_back(v(0,1,1,0, 0,2,0,0,1,0));
    tbl.push_back(v(0,0,1,0, 0,2,0,0,0,0));
    push_addrs(0, 8);
    push_addrs(0, 2);
    for (int i = 0; i < tbl.size(); i++) begin
      bus.run          = tbl[i].run;
      bus.clr_cap_done = tbl[i].clr;
      bus.wrt_smpl     = tbl[i].wrt;
      bus.triggered    = tbl[i].trig;
      neg();
      chk($sformatf("tbl%0d", i),
          32'(outs()), 32'(tbl[i].exp));
      pos();
    end
    bus.run          = 1'b0;
    bus.clr_cap_done = 1'b0;
    chk("tbl_sb_drained", exp_q.size(), 0);

    // trig_pos=0: no post-trigger writes
    bus.trig_pos = 3'd0;
    bus.wrt_smpl = 1'b0;
    bus.run      = 1'b1;
    step();
    bus.run      = 1'b0;
    bus.wrt_smpl = 1'b1;
    push_addrs(0, 4);
    for (int i = 0; i < 4; i++) step();
    bus.wrt_smpl  = 1'b0;
    bus.triggered = 1'b1;
    step();
    bus.wrt_smpl = 1'b1;
    neg();
    chk("tp0_post_we", bus.we, 0);
    chk("tp0_post_busy", bus.busy, 1);
    pos();
    bus.triggered = 1'b0;
    bus.wrt_smpl  = 1'b0;
    neg();
    chk("tp0_sd", bus.set_capture_done, 1);
    chk("tp0_cd", bus.capture_done, 1);
    chk("tp0_waddr", bus.waddr, 4);
    chk("tp0_armed", bus.armed, 0);
    pos();
    neg();
    chk("tp0_sd_once", bus.set_capture_done, 0);
    pos();
    bus.clr_cap_done = 1'b1;
    step();
    bus.clr_cap_done = 1'b0;
    chk("tp0_sb_drained", exp_q.size(), 0);

    // sparse strobes every 3rd cycle, trig_pos=2
    bus.trig_pos = 3'd2;
    bus.run      = 1'b1;
    step();
    bus.run = 1'b0;
    push_addrs(0, 8);
    push_addrs(0, 1);
    for (int c = 0; c < 29; c++) begin
      bus.wrt_smpl  = (c % 3 == 0);
      bus.triggered = (c >= 19);
      neg();
      chk($sformatf("sp_we%0d", c), bus.we,
          32'((c % 3 == 0) && (c <= 24)));
      chk($sformatf("sp_arm%0d", c), bus.armed,
          32'((c >= 16) && (c <= 25)));
      chk($sformatf("sp_sd%0d", c),
          bus.set_capture_done, 32'(c == 26));
      chk($sformatf("sp_busy%0d", c), bus.busy,
          32'(c <= 25));
      pos();
    end
    chk("sp_waddr", bus.waddr, 1);
    chk("sp_cd", bus.capture_done, 1);
    chk("sp_sb_drained", exp_q.size(), 0);
    bus.triggered    = 1'b0;
    bus.wrt_smpl     = 1'b0;
    bus.clr_cap_done = 1'b1;
    step();
    bus.clr_cap_done = 1'b0;

    // run during POST aborts and restarts
    bus.trig_pos = 3'd3;
    bus.run      = 1'b1;
    step();
    bus.run      = 1'b0;
    bus.wrt_smpl = 1'b1;
    push_addrs(0, 3);
    step();
    bus.triggered = 1'b1;
    step();
    step();
    bus.triggered = 1'b0;
    bus.wrt_smpl  = 1'b0;
    bus.run       = 1'b1;
    step();
    bus.run = 1'b0;
    neg();
    chk("ab_busy", bus.busy, 1);
    chk("ab_waddr", bus.waddr, 0);
    chk("ab_armed", bus.armed, 0);
    chk("ab_sd", bus.set_capture_done, 0);
    pos();
    bus.wrt_smpl = 1'b1;
    push_addrs(0, 8);
    push_addrs(0, 2);
    for (int i = 0; i < 7; i++) begin
      bus.triggered = (i == 6);
      step();
    end
    n = 0;
    while (1) begin
      neg();
      if (bus.set_capture_done === 1'b1) break;
      if (n == 10) break;
      n++;
      pos();
    end
    chk("ab_done_lat", n, 4);
    chk("ab_cd", bus.capture_done, 1);
    chk("ab_waddr_end", bus.waddr, 2);
    chk("ab_sb_drained", exp_q.size(), 0);
    pos();

    // run + clear together in DONE: clear wins
    bus.triggered    = 1'b0;
    bus.run          = 1'b1;
    bus.clr_cap_done = 1'b1;
    step();
    bus.run          = 1'b0;
    bus.clr_cap_done = 1'b0;
    neg();
    chk("rc_cd", bus.capture_done, 0);
    chk("rc_busy", bus.busy, 0);
    chk("rc_we", bus.we, 0);
    pos();
    step();
    step();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    push_addrs(0, 7);
    for (int i = 0; i < 6; i++) begin
      bus.triggered = (i == 5);
      step();
    end
    step();
    chk("rs_busy", bus.busy, 1);
    chk("rs_armed", bus.armed, 1);

    // asynchronous reset mid-POST
    rst_n = 1'b0;
    #1;
    chk("rst_outs", 32'(outs()), 32'h0);
    chk("rs_sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Capture sequencer for the logic analyzer sample buffer. A run command starts a capture. The block then writes samples into a circular RAM, waits until enough pre-trigger history exists, and drives armed to the trigger logic. Once triggered, it collects trig_pos post-trigger samples, pulses set_capture_done to clear the trigger, and holds capture_done until software clears it.

Parameters:
ADDR_W, 9, sample RAM address width; DEPTH = 2**ADDR_W entries

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
run  input  1  one-cycle capture start/restart command
clr_cap_done  input  1  one-cycle clear of capture_done status
wrt_smpl  input  1  a new (decimated) sample is valid this cycle
triggered  input  1  sticky trigger flag from the trigger logic
trig_pos  input  ADDR_W  number of samples to keep after the trigger (0..DEPTH-1)
we  output  1  RAM write enable (combinational)
waddr  output  ADDR_W  RAM write address (registered)
armed  output  1  pre-trigger history full; trigger may fire (registered)
set_capture_done  output  1  one-cycle pulse on capture completion (registered)
capture_done  output  1  sticky completion status (registered)
busy  output  1  high in WRT or POST (combinational)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: state=IDLE. waddr, smpl_cnt, post_cnt, armed, set_capture_done and capture_done are all 0. we=0, busy=0.
- States: IDLE, WRT (pre-trigger fill), POST (post-trigger collect), DONE.
- we = wrt_smpl & (state==WRT | (state==POST & post_cnt!=trig_pos)).
- Every we: write at the current waddr, then waddr <= waddr+1. waddr wraps DEPTH-1 -> 0.
- IDLE: run -> WRT. Clear waddr, smpl_cnt, post_cnt and armed.
- WRT:
  - On each we, smpl_cnt increments (ADDR_W+1 bits) and saturates at DEPTH.
  - armed is registered: it goes high the cycle after smpl_cnt >= DEPTH - trig_pos, then stays high.
  - triggered=1 -> POST. A triggered seen while armed=0 is still honoured; the trigger logic gates on armed.
- POST:
  - On each we, post_cnt increments.
  - When post_cnt==trig_pos (checked every cycle, no write that cycle): go to DONE. Next cycle set_capture_done=1 for exactly one cycle. Set capture_done=1 and clear armed.
  - trig_pos=0: DONE on the first POST cycle, with zero post-trigger writes.
- DONE:
  - waddr is frozen and equals the address of the oldest sample (read start pointer).
  - capture_done holds until clr_cap_done -> IDLE.
  - run is ignored in DONE.
  - clr_cap_done and run in the same cycle: clear wins, state=IDLE, the run is dropped.
- run while in WRT or POST: abort and restart. Counters, waddr and armed are cleared; state=WRT; set_capture_done is not pulsed.
- clr_cap_done outside DONE: no effect.
- trig_pos is sampled continuously; software must hold it stable during a capture. It is not latched.
- Reset mid-capture: immediate return to the reset values above, no set_capture_done pulse.

Test Plan:
- Reset: assert rst_n=0 mid-POST -> we=0, waddr=0, armed=0, capture_done=0 and state IDLE, all asynchronously without a clock edge.
- ADDR_W=3, trig_pos=3, wrt_smpl=1 continuously, run pulse:
  - armed rises the cycle after the 5th write.
  - triggered raised after the 7th write (waddr=7) -> 3 POST writes to addresses 7,0,1.
  - set_capture_done single pulse; capture_done=1, waddr=2, armed=0.
- trig_pos=0, triggered in WRT -> no POST writes, set_capture_done pulses, waddr unchanged from its trigger-cycle value.
- wrt_smpl asserted every 3rd cycle, trig_pos=2 -> we only on wrt_smpl cycles; completion exactly 2 sample strobes after the trigger; armed timing counts strobes, not clocks.
- run pulsed in POST -> state WRT, waddr=0, armed=0, no set_capture_done. A new capture then completes normally.
- In DONE, run and clr_cap_done in the same cycle -> IDLE, capture_done=0, no new capture. A later run starts a capture.
